// File: rtl/gbc_bram_arbiter.sv
// Two-port arbiter sharing one single-port BRAM between the CPU path (A) and the
// cache fill engine (B); fixed A priority with a starvation guard, tagged read return.
module gbc_bram_arbiter #(
  parameter int unsigned AddressWidth = 15,
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned ReadLatency  = 1,
  parameter int unsigned StarveLimit  = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    AAccess,
  input  logic                    AWrite,
  input  logic [AddressWidth-1:0] AAddress,
  input  logic [DataWidth-1:0]    ADataIn,
  output logic                    AReady,
  output logic                    ADataReady,
  output logic [DataWidth-1:0]    ADataOut,
  input  logic                    BAccess,
  input  logic                    BWrite,
  input  logic [AddressWidth-1:0] BAddress,
  input  logic [DataWidth-1:0]    BDataIn,
  output logic                    BReady,
  output logic                    BDataReady,
  output logic [DataWidth-1:0]    BDataOut,
  output logic                    BramEn,
  output logic                    BramWrite,
  output logic [AddressWidth-1:0] BramAddress,
  output logic [DataWidth-1:0]    BramDataOut,
  input  logic [DataWidth-1:0]    BramDataIn
);

  localparam int unsigned CntWidth = 8;
  localparam logic [CntWidth-1:0] StarveMax = CntWidth'(StarveLimit);

  logic                    grant_a_c;
  logic                    grant_b_c;
  logic                    b_first_c;
  logic                    issue_rd_c;
  logic                    a_ret_c;
  logic                    b_ret_c;

  logic [CntWidth-1:0]     starve_cnt_q, starve_cnt_d;
  logic [ReadLatency-1:0]  pipe_vld_q, pipe_vld_d;
  logic [ReadLatency-1:0]  pipe_tag_q, pipe_tag_d;  // tag 1 = port B
  logic [DataWidth-1:0]    a_data_q, a_data_d;
  logic [DataWidth-1:0]    b_data_q, b_data_d;

  // Grant: A wins contention unless B has waited StarveLimit cycles.
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    b_first_c = (starve_cnt_q == StarveMax);
    if (Reset) begin
      if (AAccess && BAccess) begin
        grant_b_c = b_first_c;
        grant_a_c = !b_first_c;
      end else begin
        grant_a_c = AAccess;
        grant_b_c = BAccess;
      end
    end
  end

  // BRAM drive; idle address/data follow port A, zero while in reset.
  always_comb begin
    AReady      = grant_a_c;
    BReady      = grant_b_c;
    BramEn      = grant_a_c | grant_b_c;
    BramWrite   = (grant_a_c & AWrite) | (grant_b_c & BWrite);
    BramAddress = '0;
    BramDataOut = '0;
    if (Reset) begin
      BramAddress = grant_b_c ? BAddress : AAddress;
      BramDataOut = grant_b_c ? BDataIn  : ADataIn;
    end
  end

  // Starvation counter and read-tag pipeline next state.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    issue_rd_c   = (grant_a_c & !AWrite) | (grant_b_c & !BWrite);
    pipe_vld_d   = ReadLatency'({pipe_vld_q, issue_rd_c});
    pipe_tag_d   = ReadLatency'({pipe_tag_q, grant_b_c});
    if (!BAccess || grant_b_c) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < StarveMax) begin
      starve_cnt_d = starve_cnt_q + CntWidth'(1);
    end
  end

  // Read return: the pipe output lines up with the cycle BramDataIn is valid.
  always_comb begin
    a_ret_c    = Reset & pipe_vld_q[ReadLatency-1] & !pipe_tag_q[ReadLatency-1];
    b_ret_c    = Reset & pipe_vld_q[ReadLatency-1] &  pipe_tag_q[ReadLatency-1];
    a_data_d   = a_ret_c ? BramDataIn : a_data_q;
    b_data_d   = b_ret_c ? BramDataIn : b_data_q;
    ADataReady = a_ret_c;
    BDataReady = b_ret_c;
    ADataOut   = a_data_d;
    BDataOut   = b_data_d;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      starve_cnt_q <= '0;
      pipe_vld_q   <= '0;
      pipe_tag_q   <= '0;
      a_data_q     <= '0;
      b_data_q     <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_tag_q   <= pipe_tag_d;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
    end
  end

endmodule

// File: tb/tb_gbc_bram_arbiter.sv
// Bench for gbc_bram_arbiter: three instances (ReadLatency 1/2/3) share stimulus,
// each with its own BRAM model; a due-time scoreboard predicts read returns.
module tb_gbc_bram_arbiter;

  logic        Clk, Reset;
  logic        AAccess, AWrite, BAccess, BWrite;
  logic [14:0] AAddress, BAddress;
  logic [7:0]  ADataIn, BDataIn;

  logic [2:0]  a_ready, b_ready, a_drdy, b_drdy, bram_en, bram_wr;
  logic [7:0]  a_dout [3];
  logic [7:0]  b_dout [3];
  logic [7:0]  bram_dout [3];
  logic [14:0] bram_addr [3];

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  // Reference model state
  logic [7:0]  ref_mem [32768];
  int unsigned starve;
  int unsigned cyc;
  bit          exp_v [3][16];
  bit          exp_b [3][16];
  logic [7:0]  exp_d [3][16];
  logic [7:0]  exp_ad [3];
  logic [7:0]  exp_bd [3];

  function automatic logic [7:0] init_byte(input logic [14:0] a);
    if (a == 15'h0100) return 8'h5A;
    return (a[7:0] ^ {a[14:8], 1'b0}) + 8'h11;
  endfunction

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned Lat = g + 1;
    logic [7:0] mem [32768];
    logic [7:0] rd_pipe [Lat];

    initial begin
      for (int i = 0; i < 32768; i++) mem[i] = init_byte(15'(i));
    end

    always @(posedge Clk) begin
      if (bram_en[g] && bram_wr[g]) mem[bram_addr[g]] = bram_dout[g];
      rd_pipe[0] <= (bram_en[g] && !bram_wr[g]) ? mem[bram_addr[g]] : 8'hEE;
      for (int k = 1; k < Lat; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    gbc_bram_arbiter #(
      .AddressWidth(15), .DataWidth(8), .ReadLatency(Lat), .StarveLimit(8)
    ) u_dut (
      .Clk(Clk), .Reset(Reset),
      .AAccess(AAccess), .AWrite(AWrite), .AAddress(AAddress), .ADataIn(ADataIn),
      .AReady(a_ready[g]), .ADataReady(a_drdy[g]), .ADataOut(a_dout[g]),
      .BAccess(BAccess), .BWrite(BWrite), .BAddress(BAddress), .BDataIn(BDataIn),
      .BReady(b_ready[g]), .BDataReady(b_drdy[g]), .BDataOut(b_dout[g]),
      .BramEn(bram_en[g]), .BramWrite(bram_wr[g]), .BramAddress(bram_addr[g]),
      .BramDataOut(bram_dout[g]), .BramDataIn(rd_pipe[Lat-1])
    );
  end

  // Expected grant {B, A} from the current inputs and the denied-B streak.
  function automatic logic [1:0] model_grant();
    if (!Reset) return 2'b00;
    if (AAccess && BAccess) return (starve >= 8) ? 2'b10 : 2'b01;
    return {BAccess, AAccess};
  endfunction

  function automatic logic [14:0] rand_addr();
    logic [14:0] base;
    base = ($urandom_range(0, 1) != 0) ? 15'h7FF0 : 15'h0000;
    return base + 15'($urandom_range(0, 15));
  endfunction

  // Advance one clock, updating the reference model with this cycle's traffic.
  task automatic tick();
    logic [1:0]  g;
    int unsigned s, t;
    g = model_grant();
    s = cyc % 16;
    if (!Reset) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 16; j++) exp_v[i][j] = 1'b0;
        exp_ad[i] = 8'h00;
        exp_bd[i] = 8'h00;
      end
      starve = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (exp_v[i][s]) begin
          if (exp_b[i][s]) exp_bd[i] = exp_d[i][s];
          else             exp_ad[i] = exp_d[i][s];
          exp_v[i][s] = 1'b0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (g[p]) begin
          if ((p == 0) ? AWrite : BWrite) begin
            if (p == 0) ref_mem[AAddress] = ADataIn;
            else        ref_mem[BAddress] = BDataIn;
          end else begin
            for (int i = 0; i < 3; i++) begin
              t = (cyc + 32'(i) + 1) % 16;
              exp_v[i][t] = 1'b1;
              exp_b[i][t] = (p == 1);
              exp_d[i][t] = (p == 0) ? ref_mem[AAddress] : ref_mem[BAddress];
            end
          end
        end
      end
      if (BAccess && !g[1]) starve = (starve < 8) ? starve + 1 : starve;
      else                  starve = 0;
    end
    cyc++;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    AAccess = 1'b0;
    BAccess = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    AAccess = 1'b1; AWrite = 1'b0; AAddress = 15'h0010; ADataIn = 8'h00;
    BAccess = 1'b1; BWrite = 1'b0; BAddress = 15'h0020; BDataIn = 8'h00;
    for (int r = 0; r < 3; r++) begin
      #2;
      compared++;
      if ({a_ready, b_ready, bram_en, bram_wr} !== 12'h000) begin
        mismatched++;
        $display("FAIL reset_strobes: got ready=%b/%b en=%b wr=%b expected all 0", a_ready, b_ready, bram_en, bram_wr);
      end
      compared++;
      if ({a_drdy, b_drdy} !== 6'b0 || bram_addr[0] !== 15'h0 || bram_dout[0] !== 8'h0) begin
        mismatched++;
        $display("FAIL reset_outputs: got drdy=%b/%b addr=%h data=%h expected 0", a_drdy, b_drdy, bram_addr[0], bram_dout[0]);
      end
      if (r > 0) begin
        for (int i = 0; i < 3; i++) begin
          compared++;
          if (a_dout[i] !== 8'h00 || b_dout[i] !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_dataout[%0d]: got %h/%h expected 00/00", i, a_dout[i], b_dout[i]);
          end
        end
      end
      tick();
    end
    Reset = 1'b1;
    #2;
    compared++;
    if (a_ready !== 3'b111 || b_ready !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_release_grant: got A=%b B=%b expected A=111 B=000", a_ready, b_ready);
    end
    tick();
    idle(4);
  endtask

  task automatic test_single_read();
    AAccess = 1'b1; AWrite = 1'b0; AAddress = 15'h0100;
    #2;
    compared++;
    if (a_ready !== 3'b111 || bram_addr[0] !== 15'h0100 || bram_wr[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL single_issue: got ready=%b addr=%h wr=%b expected 111/0100/0", a_ready, bram_addr[0], bram_wr[0]);
    end
    tick();
    AAccess = 1'b0;
    #2;
    compared++;
    if (a_drdy[0] !== 1'b1 || a_dout[0] !== 8'h5A) begin
      mismatched++;
      $display("FAIL single_return: got drdy=%b data=%h expected 1/5a", a_drdy[0], a_dout[0]);
    end
    compared++;
    if (b_drdy !== 3'b000) begin
      mismatched++;
      $display("FAIL single_b_quiet: got %b expected 000", b_drdy);
    end
    tick();
    idle(4);
  endtask

  task automatic test_starvation();
    bit exp_bg;
    BAccess = 1'b1; BWrite = 1'b0; BAddress = rand_addr();
    for (int k = 0; k < 18; k++) begin
      AAccess = 1'b1; AWrite = 1'b0; AAddress = rand_addr();
      exp_bg = (k % 9 == 8);
      #2;
      compared++;
      if (a_ready !== {3{!exp_bg}} || b_ready !== {3{exp_bg}}) begin
        mismatched++;
        $display("FAIL starve_cycle%0d: got A=%b B=%b expected B grant=%0d", k, a_ready, b_ready, exp_bg);
      end
      tick();
      if (exp_bg) BAddress = rand_addr();
    end
    idle(5);
  endtask

  task automatic test_interleave();
    int  d;
    bit  v, is_b;
    logic [14:0] addr;
    for (int k = 0; k < 12; k++) begin
      AAccess = 1'b0; BAccess = 1'b0; AWrite = 1'b0; BWrite = 1'b0;
      if (k < 8) begin
        if (k % 2 == 0) begin AAccess = 1'b1; AAddress = 15'(k / 2); end
        else begin BAccess = 1'b1; BAddress = 15'h7FF0 + 15'(k / 2); end
      end
      #2;
      if (k < 8) begin
        compared++;
        if (((k % 2 == 0) ? a_ready[2] : b_ready[2]) !== 1'b1) begin
          mismatched++;
          $display("FAIL interleave_ready%0d: got A=%b B=%b", k, a_ready[2], b_ready[2]);
        end
      end
      d = k - 3;
      v = (d >= 0 && d < 8);
      is_b = v && (d % 2 == 1);
      addr = is_b ? (15'h7FF0 + 15'(d / 2)) : 15'(d / 2);
      compared++;
      if (a_drdy[2] !== (v && !is_b) || b_drdy[2] !== is_b) begin
        mismatched++;
        $display("FAIL interleave_drdy%0d: got A=%b B=%b expected A=%b B=%b", k, a_drdy[2], b_drdy[2], v && !is_b, is_b);
      end
      if (v) begin
        compared++;
        if ((is_b ? b_dout[2] : a_dout[2]) !== init_byte(addr)) begin
          mismatched++;
          $display("FAIL interleave_data%0d: got %h expected %h", k, is_b ? b_dout[2] : a_dout[2], init_byte(addr));
        end
      end
      tick();
    end
    idle(3);
  endtask

  task automatic test_write_read();
    for (int k = 0; k < 5; k++) begin
      AAccess = (k < 2); AWrite = (k == 0); AAddress = 15'h1234; ADataIn = 8'hC3;
      BAccess = 1'b0;
      #2;
      compared++;
      if (bram_wr[0] !== (k == 0)) begin
        mismatched++;
        $display("FAIL wr_strobe%0d: got %b expected %b", k, bram_wr[0], k == 0);
      end
      if (k == 0) begin
        compared++;
        if (bram_dout[0] !== 8'hC3 || bram_addr[0] !== 15'h1234) begin
          mismatched++;
          $display("FAIL wr_bus: got %h@%h expected c3@1234", bram_dout[0], bram_addr[0]);
        end
      end
      if (k == 2) begin
        compared++;
        if (a_drdy[0] !== 1'b1 || a_dout[0] !== 8'hC3) begin
          mismatched++;
          $display("FAIL wr_readback_l1: got %b/%h expected 1/c3", a_drdy[0], a_dout[0]);
        end
      end
      if (k == 4) begin
        compared++;
        if (a_drdy[2] !== 1'b1 || a_dout[2] !== 8'hC3) begin
          mismatched++;
          $display("FAIL wr_readback_l3: got %b/%h expected 1/c3", a_drdy[2], a_dout[2]);
        end
      end
      tick();
    end
    idle(3);
  endtask

  task automatic test_reset_midflight();
    AAccess = 1'b0; BAccess = 1'b1; BWrite = 1'b0; BAddress = 15'h0200;
    #2;
    compared++;
    if (b_ready[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL midflight_issue: got %b expected 1", b_ready[1]);
    end
    tick();
    BAccess = 1'b0; Reset = 1'b0;
    #2;
    compared++;
    if (b_drdy !== 3'b000) begin
      mismatched++;
      $display("FAIL midflight_in_reset: got %b expected 000", b_drdy);
    end
    tick();
    Reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      compared++;
      if (b_drdy !== 3'b000 || a_drdy !== 3'b000 || b_dout[1] !== 8'h00) begin
        mismatched++;
        $display("FAIL midflight_dropped%0d: got drdy=%b/%b data=%h expected 0", k, a_drdy, b_drdy, b_dout[1]);
      end
      tick();
    end
    BAccess = 1'b1;
    #2;
    compared++;
    if (b_ready[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL midflight_post_issue: got %b expected 1", b_ready[1]);
    end
    tick();
    BAccess = 1'b0;
    #2;
    compared++;
    if (b_drdy[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL midflight_post_early: got %b expected 0", b_drdy[1]);
    end
    tick();
    #2;
    compared++;
    if (b_drdy[1] !== 1'b1 || b_dout[1] !== init_byte(15'h0200)) begin
      mismatched++;
      $display("FAIL midflight_post_data: got %b/%h expected 1/%h", b_drdy[1], b_dout[1], init_byte(15'h0200));
    end
    tick();
    idle(3);
  endtask

  task automatic test_random();
    bit          a_pend, b_pend, ev_a, ev_b;
    logic [1:0]  g;
    logic [14:0] e_addr;
    logic [7:0]  e_data;
    int unsigned s;
    a_pend = 1'b0;
    b_pend = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!a_pend && $urandom_range(0, 1) != 0) begin
        a_pend = 1'b1; AWrite = ($urandom_range(0, 2) == 0);
        AAddress = rand_addr(); ADataIn = 8'($urandom);
      end
      if (b_pend && $urandom_range(0, 7) == 0) b_pend = 1'b0;
      else if (!b_pend && $urandom_range(0, 1) != 0) begin
        b_pend = 1'b1; BWrite = ($urandom_range(0, 2) == 0);
        BAddress = rand_addr(); BDataIn = 8'($urandom);
      end
      AAccess = a_pend;
      BAccess = b_pend;
      Reset = (n != 200);
      #2;
      g = model_grant();
      e_addr = !Reset ? 15'h0 : (g[1] ? BAddress : AAddress);
      e_data = !Reset ? 8'h0 : (g[1] ? BDataIn : ADataIn);
      compared++;
      if (a_ready !== {3{g[0]}} || b_ready !== {3{g[1]}}) begin
        mismatched++;
        $display("FAIL rand_grant%0d: got A=%b B=%b expected A=%b B=%b", n, a_ready, b_ready, g[0], g[1]);
      end
      compared++;
      if (bram_en[0] !== (|g) || bram_wr[0] !== ((g[0] & AWrite) | (g[1] & BWrite)) ||
          bram_addr[0] !== e_addr || bram_dout[0] !== e_data) begin
        mismatched++;
        $display("FAIL rand_bram%0d: got en=%b wr=%b %h@%h expected %h@%h", n, bram_en[0], bram_wr[0], bram_dout[0], bram_addr[0], e_data, e_addr);
      end
      s = cyc % 16;
      for (int i = 0; i < 3; i++) begin
        ev_a = Reset && exp_v[i][s] && !exp_b[i][s];
        ev_b = Reset && exp_v[i][s] &&  exp_b[i][s];
        compared++;
        if (a_drdy[i] !== ev_a || b_drdy[i] !== ev_b) begin
          mismatched++;
          $display("FAIL rand_drdy%0d[%0d]: got A=%b B=%b expected A=%b B=%b", n, i, a_drdy[i], b_drdy[i], ev_a, ev_b);
        end
        compared++;
        if (a_dout[i] !== (ev_a ? exp_d[i][s] : exp_ad[i]) || b_dout[i] !== (ev_b ? exp_d[i][s] : exp_bd[i])) begin
          mismatched++;
          $display("FAIL rand_dout%0d[%0d]: got A=%h B=%h expected A=%h B=%h", n, i, a_dout[i], b_dout[i],
                   ev_a ? exp_d[i][s] : exp_ad[i], ev_b ? exp_d[i][s] : exp_bd[i]);
        end
      end
      tick();
      if (g[0] || n == 200) a_pend = 1'b0;
      if (g[1] || n == 200) b_pend = 1'b0;
    end
    idle(5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_byte(15'(i));
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 16; j++) exp_v[i][j] = 1'b0;
      exp_ad[i] = 8'h00;
      exp_bd[i] = 8'h00;
    end
    starve = 0;
    cyc = 0;
    test_reset();
    test_single_read();
    test_starvation();
    test_interleave();
    test_write_read();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
